// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Shared datapath sizing and register-file constants for the CPU pipeline.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

endpackage

`default_nettype wire

// File: rtl/regfile_bank.sv
// ============================================================================
// Module : regfile_bank
// Register storage with asynchronous clear, one guarded write port and two
// raw combinational read ports. Index 0 always reads as zero.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_bank #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  import cpu_pkg::*;

  localparam int NREGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] c_zero_idx = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_wr_ok;

  assign w_wr_ok = i_we && (i_waddr != c_zero_idx);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Explicit zero on index 0 keeps r0 hardwired even if storage were disturbed.
  assign o_rdata_a = (i_raddr_a == c_zero_idx) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == c_zero_idx) ? '0 : r_regs[i_raddr_b];

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
// Module : wb_regfile
// Writeback stage: source mux, commit to the register file and a committed
// write counter. Optional write-through bypass: WB_REGFILE_BYPASS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_regfile #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wwreg,
  input  logic              wm2reg,
  input  logic [ADDR_W-1:0] wdestReg,
  input  logic [DATA_W-1:0] wr,
  input  logic [DATA_W-1:0] wdo,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic [DATA_W-1:0] wbData,
  output logic [CNT_W-1:0]  wbCount
);

  import cpu_pkg::*;

  logic              w_commit;
  logic [DATA_W-1:0] w_raw_a;
  logic [DATA_W-1:0] w_raw_b;
  logic [CNT_W-1:0]  r_count;

  assign wbData   = wm2reg ? wdo : wr;
  assign w_commit = wwreg && (wdestReg != ADDR_W'(ZERO_REG));

  regfile_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clock     (clock),
    .resetn    (resetn),
    .i_we      (w_commit),
    .i_waddr   (wdestReg),
    .i_wdata   (wbData),
    .i_raddr_a (rs),
    .i_raddr_b (rt),
    .o_rdata_a (w_raw_a),
    .o_rdata_b (w_raw_b)
  );

`ifdef WB_REGFILE_BYPASS_EN
  // w_commit already excludes index 0, so r0 can never be bypassed.
  assign qa = (w_commit && (rs == wdestReg)) ? wbData : w_raw_a;
  assign qb = (w_commit && (rt == wdestReg)) ? wbData : w_raw_b;
`else
  assign qa = w_raw_a;
  assign qb = w_raw_b;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (w_commit) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign wbCount = r_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module : tb_wb_regfile
// Self-checking bench for wb_regfile against an array-based reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_regfile;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        wwreg = 1'b0;
  logic        wm2reg = 1'b0;
  logic [4:0]  wdestReg = '0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic [31:0] wr = '0;
  logic [31:0] wdo = '0;

  logic [31:0] qa, qb, wbData, wbCount;
  logic [31:0] qa4, qb4, wbData4;
  logic [3:0]  wbCount4;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]     mregs [32];
  longint unsigned mcount;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clock(clock), .resetn(resetn), .wwreg(wwreg), .wm2reg(wm2reg),
    .wdestReg(wdestReg), .wr(wr), .wdo(wdo), .rs(rs), .rt(rt),
    .qa(qa), .qb(qb), .wbData(wbData), .wbCount(wbCount)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
    .clock(clock), .resetn(resetn), .wwreg(wwreg), .wm2reg(wm2reg),
    .wdestReg(wdestReg), .wr(wr), .wdo(wdo), .rs(rs), .rt(rt),
    .qa(qa4), .qb(qb4), .wbData(wbData4), .wbCount(wbCount4)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] exp_wb();
    return wm2reg ? wdo : wr;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (wwreg && wdestReg != 5'd0 && idx == wdestReg) return exp_wb();
`endif
    return mregs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcount = 0;
  endtask

  task automatic set_in(input logic we, input logic m2r, input logic [4:0] dest,
                        input logic [31:0] r, input logic [31:0] d,
                        input logic [4:0] a, input logic [4:0] b);
    @(negedge clock);
    wwreg = we; wm2reg = m2r; wdestReg = dest; wr = r; wdo = d; rs = a; rt = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    if (wwreg && wdestReg != 5'd0) begin
      mregs[wdestReg] = exp_wb();
      mcount++;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    resetn = 1'b0;
    rs = 5'd5; rt = 5'd7;
    #12;
    n_cmp++; if (qa !== 32'd0) begin n_bad++; $display("FAIL reset_qa: got %h want %h", qa, 32'd0); end
    n_cmp++; if (qb !== 32'd0) begin n_bad++; $display("FAIL reset_qb: got %h want %h", qb, 32'd0); end
    n_cmp++; if (wbCount !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", wbCount); end
    @(negedge clock);
    resetn = 1'b1;
    set_in(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 5'd5, 5'd5);
    tick();
    n_cmp++; if (qa !== 32'hDEADBEEF) begin n_bad++; $display("FAIL pre_reset_write: got %h want %h", qa, 32'hDEADBEEF); end
    // Mid-cycle asynchronous pulse, released before the next rising edge.
    @(negedge clock);
    wwreg = 1'b0;
    #2 resetn = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (qa !== 32'd0) begin n_bad++; $display("FAIL async_clear_qa: got %h want %h", qa, 32'd0); end
    n_cmp++; if (wbCount !== 32'd0) begin n_bad++; $display("FAIL async_clear_cnt: got %0d want 0", wbCount); end
    #1 resetn = 1'b1;
  endtask

  task automatic test_source_select();
    set_in(1'b1, 1'b1, 5'd7, 32'hAAAAAAAA, 32'h12345678, 5'd7, 5'd7);
    n_cmp++; if (wbData !== 32'h12345678) begin n_bad++; $display("FAIL wbdata_mem: got %h want %h", wbData, 32'h12345678); end
    tick();
    n_cmp++; if (qa !== 32'h12345678) begin n_bad++; $display("FAIL sel_mem_qa: got %h want %h", qa, 32'h12345678); end
    n_cmp++; if (wbCount !== 32'd1) begin n_bad++; $display("FAIL sel_mem_cnt: got %0d want 1", wbCount); end
    set_in(1'b1, 1'b0, 5'd7, 32'hAAAAAAAA, 32'h12345678, 5'd7, 5'd7);
    n_cmp++; if (wbData !== 32'hAAAAAAAA) begin n_bad++; $display("FAIL wbdata_alu: got %h want %h", wbData, 32'hAAAAAAAA); end
    tick();
    n_cmp++; if (qb !== 32'hAAAAAAAA) begin n_bad++; $display("FAIL sel_alu_qb: got %h want %h", qb, 32'hAAAAAAAA); end
    n_cmp++; if (wbCount !== 32'd2) begin n_bad++; $display("FAIL sel_alu_cnt: got %0d want 2", wbCount); end
  endtask

  task automatic test_zero_reg();
    set_in(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0);
    tick();
    n_cmp++; if (qa !== 32'd0) begin n_bad++; $display("FAIL zero_qa: got %h want 0", qa); end
    n_cmp++; if (qb !== 32'd0) begin n_bad++; $display("FAIL zero_qb: got %h want 0", qb); end
    n_cmp++; if (wbCount !== 32'(mcount)) begin n_bad++; $display("FAIL zero_cnt: got %0d want %0d", wbCount, mcount); end
  endtask

  task automatic test_write_disable();
    set_in(1'b0, 1'b0, 5'd3, 32'h55, 32'h0, 5'd3, 5'd3);
    tick();
    n_cmp++; if (qa !== 32'd0) begin n_bad++; $display("FAIL wdis_qa: got %h want 0", qa); end
    n_cmp++; if (wbCount !== 32'(mcount)) begin n_bad++; $display("FAIL wdis_cnt: got %0d want %0d", wbCount, mcount); end
  endtask

  task automatic test_same_cycle_read();
    logic [31:0] want;
    set_in(1'b1, 1'b0, 5'd9, 32'h42, 32'h0, 5'd9, 5'd0);
`ifdef WB_REGFILE_BYPASS_EN
    want = 32'h42;
`else
    want = 32'h0;
`endif
    n_cmp++; if (qa !== want) begin n_bad++; $display("FAIL same_cycle_pre: got %h want %h", qa, want); end
    tick();
    set_in(1'b0, 1'b0, 5'd9, 32'h0, 32'h0, 5'd9, 5'd9);
    n_cmp++; if (qa !== 32'h42) begin n_bad++; $display("FAIL same_cycle_post: got %h want %h", qa, 32'h42); end
  endtask

  task automatic test_counter_wrap();
    @(negedge clock);
    wwreg = 1'b0;
    resetn = 1'b0;
    model_reset();
    #2 resetn = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_in(1'b1, 1'($urandom_range(0, 1)), 5'd1, $urandom, $urandom, 5'd1, 5'd2);
      tick();
    end
    set_in(1'b0, 1'b0, 5'd1, 32'h0, 32'h0, 5'd1, 5'd1);
    n_cmp++; if (wbCount4 !== 4'd1) begin n_bad++; $display("FAIL wrap_cnt4: got %0d want 1", wbCount4); end
    n_cmp++; if (wbCount !== 32'd17) begin n_bad++; $display("FAIL wrap_cnt32: got %0d want 17", wbCount); end
    n_cmp++; if (qa4 !== mregs[1]) begin n_bad++; $display("FAIL wrap_r1: got %h want %h", qa4, mregs[1]); end
  endtask

  task automatic test_random();
    logic [31:0] ea, eb;
    for (int i = 0; i < 300; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), $urandom, $urandom,
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) rs = wdestReg;
      if ($urandom_range(0, 3) == 0) rt = rs;
      #1;
      ea = exp_read(rs);
      eb = exp_read(rt);
      n_cmp++; if (qa !== ea) begin n_bad++; $display("FAIL rand_qa[%0d]: rs=%0d got %h want %h", i, rs, qa, ea); end
      n_cmp++; if (qb !== eb) begin n_bad++; $display("FAIL rand_qb[%0d]: rt=%0d got %h want %h", i, rt, qb, eb); end
      n_cmp++; if (wbData !== exp_wb()) begin n_bad++; $display("FAIL rand_wb[%0d]: got %h want %h", i, wbData, exp_wb()); end
      tick();
      n_cmp++; if (wbCount !== 32'(mcount)) begin n_bad++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, wbCount, mcount); end
      n_cmp++; if (wbCount4 !== 4'(mcount)) begin n_bad++; $display("FAIL rand_cnt4[%0d]: got %0d want %0d", i, wbCount4, 4'(mcount)); end
    end
  endtask

  initial begin
    test_reset();
    test_source_select();
    test_zero_reg();
    test_write_disable();
    test_same_cycle_read();
    test_counter_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
